// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared MD op codes, op width and controller state encoding.
package mdu_ctrl_pkg;
    localparam int MD_OP_W = 4;
    localparam logic [MD_OP_W-1:0] MD_NONE = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [MD_OP_W-1:0] op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction
endpackage

// File: rtl/mdu_ctrl_md_calc.sv
// md_calc: combinational multiply/divide datapath producing HI/LO results.
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        src1,
    input  logic [31:0]        src2,
    output logic [31:0]        hi_res,
    output logic [31:0]        lo_res,
    output logic               div_zero
);
    logic [63:0] sprod, uprod;
    logic [31:0] bsafe, ua, ub, sq, sr, uq, ur;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of trapping.
    always_comb begin
        sprod = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
        uprod = {32'd0, src1} * {32'd0, src2};
        bsafe = (src2 == 32'd0) ? 32'd1 : src2;
        ua = src1[31] ? -src1 : src1;
        ub = bsafe[31] ? -bsafe : bsafe;
        sq = (src1[31] ^ bsafe[31]) ? -(ua / ub) : ua / ub;
        sr = src1[31] ? -(ua % ub) : ua % ub;
        uq = src1 / bsafe;
        ur = src1 % bsafe;
        div_zero = (op == MD_DIV || op == MD_DIVU) && src2 == 32'd0;
        hi_res = (op == MD_MULT) ? sprod[63:32] :
                 (op == MD_MULTU) ? uprod[63:32] :
                 (op == MD_DIV) ? sr :
                 (op == MD_DIVU) ? ur : 32'd0;
        lo_res = (op == MD_MULT) ? sprod[31:0] :
                 (op == MD_MULTU) ? uprod[31:0] :
                 (op == MD_DIV) ? sq :
                 (op == MD_DIVU) ? uq : 32'd0;
    end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency multiply/divide sequencer owning HI/LO, with stall and cancel handling.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] E_mdOp,
    input  logic               E_cancel,
    input  logic [31:0]        MDU_src1,
    input  logic [31:0]        MDU_src2,
    input  logic               D_isMD,
    output logic [31:0]        E_MDU_result,
    output logic               E_busy,
    output logic               MDU_stall,
    output logic [31:0]        HI_out,
    output logic [31:0]        LO_out
);
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW = $clog2(MAX_LAT) + 1;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
    logic dz_pend_q, dz_pend_d;
    logic [31:0] hi_res, lo_res;
    logic div_zero, start, is_mul;

    md_calc u_calc (
        .op(E_mdOp),
        .src1(MDU_src1),
        .src2(MDU_src2),
        .hi_res(hi_res),
        .lo_res(lo_res),
        .div_zero(div_zero)
    );

    assign start = is_arith(E_mdOp) && !E_cancel && state_q == IDLE;
    assign is_mul = E_mdOp == MD_MULT || E_mdOp == MD_MULTU;
    assign E_busy = state_q != IDLE;
    assign MDU_stall = D_isMD && (E_busy || start);
    assign HI_out = hi_q;
    assign LO_out = lo_q;
    assign E_MDU_result = (E_mdOp == MD_MFHI) ? hi_q : (E_mdOp == MD_MFLO) ? lo_q : 32'd0;

    // Ops seen while busy are dropped; cancel never aborts an op already in flight.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        dz_pend_d = dz_pend_q;
        if (state_q == IDLE) begin
            if (start) begin
                hi_pend_d = hi_res;
                lo_pend_d = lo_res;
                dz_pend_d = div_zero;
                cnt_d = is_mul ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
                state_d = is_mul ? MUL_BUSY : DIV_BUSY;
            end else if (!E_cancel) begin
                hi_d = (E_mdOp == MD_MTHI) ? MDU_src1 : hi_q;
                lo_d = (E_mdOp == MD_MTLO) ? MDU_src1 : lo_q;
            end
        end else if (cnt_q == '0) begin
            hi_d = dz_pend_q ? hi_q : hi_pend_q;
            lo_d = dz_pend_q ? lo_q : lo_pend_q;
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            dz_pend_q <= dz_pend_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl using immediate assertions.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] E_mdOp = 4'd0;
    logic E_cancel = 1'b0;
    logic [31:0] MDU_src1 = 32'd0;
    logic [31:0] MDU_src2 = 32'd0;
    logic D_isMD = 1'b0;
    logic [31:0] E_MDU_result, HI_out, LO_out;
    logic E_busy, MDU_stall;
    int checks = 0;
    int failures = 0;

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk),
        .reset(reset),
        .E_mdOp(E_mdOp),
        .E_cancel(E_cancel),
        .MDU_src1(MDU_src1),
        .MDU_src2(MDU_src2),
        .D_isMD(D_isMD),
        .E_MDU_result(E_MDU_result),
        .E_busy(E_busy),
        .MDU_stall(MDU_stall),
        .HI_out(HI_out),
        .LO_out(LO_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one arithmetic op, then count busy cycles; optionally pulse cancel or inject an mthi mid-flight.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic isd, input int cancel_at, input int inject_at, input int exp_n);
        int n;
        D_isMD = isd;
        E_mdOp = op;
        MDU_src1 = a;
        MDU_src2 = b;
        E_cancel = 1'b0;
        #1;
        chk({tag, " stall_start"}, {31'd0, MDU_stall}, {31'd0, isd});
        tick();
        E_mdOp = MD_NONE;
        n = 0;
        while (E_busy && n < 40) begin
            n++;
            E_cancel = (n == cancel_at);
            E_mdOp = (n == inject_at) ? MD_MTHI : MD_NONE;
            MDU_src1 = (n == inject_at) ? 32'hDEADBEEF : a;
            #1;
            chk({tag, " stall_busy"}, {31'd0, MDU_stall}, {31'd0, isd});
            tick();
        end
        E_cancel = 1'b0;
        E_mdOp = MD_NONE;
        #1;
        chk({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " stall_after"}, {31'd0, MDU_stall}, 32'd0);
    endtask

    task automatic write_hl(input logic [3:0] op, input logic [31:0] v, input logic cancel);
        E_mdOp = op;
        MDU_src1 = v;
        E_cancel = cancel;
        tick();
        E_mdOp = MD_NONE;
        E_cancel = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset busy", {31'd0, E_busy}, 32'd0);
        chk("reset stall", {31'd0, MDU_stall}, 32'd0);
        chk("reset hi", HI_out, 32'd0);
        chk("reset lo", LO_out, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 0, 0, 5);
        chk("mult hi", HI_out, 32'hFFFFFFFF);
        chk("mult lo", LO_out, 32'hFFFFFFFA);
        E_mdOp = MD_MFLO;
        #1;
        chk("mflo", E_MDU_result, 32'hFFFFFFFA);
        E_mdOp = MD_MFHI;
        #1;
        chk("mfhi", E_MDU_result, 32'hFFFFFFFF);
        E_mdOp = MD_NONE;
        #1;
        chk("result none", E_MDU_result, 32'd0);
        tick();

        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 0, 5);
        chk("multu hi", HI_out, 32'h00000001);
        chk("multu lo", LO_out, 32'hFFFFFFFE);

        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0, 10);
        chk("div lo", LO_out, 32'hFFFFFFFD);
        chk("div hi", HI_out, 32'hFFFFFFFF);

        write_hl(MD_MTHI, 32'h12345678, 1'b0);
        write_hl(MD_MTLO, 32'h12345678, 1'b0);
        chk("mthi", HI_out, 32'h12345678);
        chk("mtlo", LO_out, 32'h12345678);
        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 1'b0, 0, 2, 10);
        chk("divu0 hi", HI_out, 32'h12345678);
        chk("divu0 lo", LO_out, 32'h12345678);

        run_op("mult_stall", MD_MULT, 32'd3, 32'd4, 1'b1, 0, 0, 5);
        chk("mult_stall hi", HI_out, 32'd0);
        chk("mult_stall lo", LO_out, 32'd12);
        D_isMD = 1'b0;

        E_mdOp = MD_MULT;
        MDU_src1 = 32'd9;
        MDU_src2 = 32'd9;
        E_cancel = 1'b1;
        tick();
        E_mdOp = MD_NONE;
        E_cancel = 1'b0;
        chk("cancel busy", {31'd0, E_busy}, 32'd0);
        tick();
        chk("cancel busy2", {31'd0, E_busy}, 32'd0);
        chk("cancel hi", HI_out, 32'd0);
        chk("cancel lo", LO_out, 32'd12);
        write_hl(MD_MTLO, 32'h0000ABCD, 1'b1);
        chk("cancel mtlo", LO_out, 32'd12);

        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, 10);
        chk("div_ovf lo", LO_out, 32'h80000000);
        chk("div_ovf hi", HI_out, 32'd0);

        run_op("div_cancel", MD_DIV, 32'd100, 32'd7, 1'b0, 3, 0, 10);
        chk("div_cancel lo", LO_out, 32'd14);
        chk("div_cancel hi", HI_out, 32'd2);

        E_mdOp = MD_DIV;
        MDU_src1 = 32'd50;
        MDU_src2 = 32'd5;
        tick();
        E_mdOp = MD_NONE;
        chk("rst busy1", {31'd0, E_busy}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy", {31'd0, E_busy}, 32'd0);
        chk("rst hi", HI_out, 32'd0);
        chk("rst lo", LO_out, 32'd0);
        tick();
        chk("rst busy later", {31'd0, E_busy}, 32'd0);
        chk("rst lo later", LO_out, 32'd0);
        write_hl(MD_MTHI, 32'h00000055, 1'b0);
        E_mdOp = MD_MFHI;
        #1;
        chk("rst mfhi", E_MDU_result, 32'h00000055);
        E_mdOp = MD_NONE;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller.
- Sits in the E stage beside the ALU and owns the HI/LO registers.
- Executes mult/multu/div/divu with fixed latency and serves mfhi/mflo/mthi/mtlo.
- Raises a stall to the hazard unit while a D-stage MD instruction must wait.
- Honours the exception-flush cancel, so a cancelled E-stage instruction never changes HI/LO.

Parameters:
- MUL_LAT, 5: busy cycles for mult/multu (≥1).
- DIV_LAT, 10: busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- E_mdOp  input  4  E-stage MD operation code (shared constants).
- E_cancel  input  1  E-stage instruction flushed this cycle (exception/interrupt); suppresses all state changes it would cause.
- MDU_src1  input  32  rs operand (dividend / multiplicand / mt data).
- MDU_src2  input  32  rt operand (divisor / multiplier).
- D_isMD  input  1  D-stage instruction is any MD op (mult..mtlo).
- E_MDU_result  output  32  mfhi → HI, mflo → LO, else 0; combinational.
- E_busy  output  1  operation in flight.
- MDU_stall  output  1  stall request to hazard unit.
- HI_out  output  32  current HI.
- LO_out  output  32  current LO.

Behaviour:
- Op codes:
  - MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Codes 9–15 behave as MD_NONE.
- start = E_mdOp ∈ {MULT..DIVU} && !E_cancel && state==IDLE.
- Reset: state=IDLE, counter=0, HI=LO=0, pending regs=0, E_busy=0, MDU_stall=0.
- States: IDLE, MUL_BUSY, DIV_BUSY.
- IDLE:
  - On start, latch the full result into hi_pend/lo_pend.
  - Load counter with MUL_LAT-1 or DIV_LAT-1.
  - Go to MUL_BUSY or DIV_BUSY.
- BUSY:
  - If counter==0: commit HI=hi_pend, LO=lo_pend, go to IDLE.
  - Else decrement counter.
- Timing for a start sampled at edge T:
  - E_busy=1 exactly N cycles (N = MUL_LAT or DIV_LAT).
  - HI/LO change at the edge ending the Nth busy cycle.
  - The same edge drops E_busy.
  - mfhi/mflo in the following cycle reads the new value.
- E_busy = (state != IDLE).
- MDU_stall = D_isMD && (E_busy || start).
- Arithmetic:
  - mult: signed 32×32 → 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32 → 64.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - Divisor==0 (div/divu): operation still occupies DIV_LAT busy cycles; HI/LO are left unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- mthi/mtlo:
  - Write HI/LO at the edge, only when !E_cancel && state==IDLE.
  - The result is visible the next cycle.
- Any E_mdOp arriving while busy (cannot happen given the stall) is ignored. The bench checks this with an assertion.
- E_cancel with a multiply/divide op: no start, state stays IDLE, no busy.
- E_cancel never aborts an operation already in flight; it completes and commits.
- reset asserted mid-operation: abort immediately to the reset values; the pending result is discarded.
- E_MDU_result is independent of busy. The hazard unit guarantees mf* never reaches E while busy.

Decomposition:
- Shared include "MDUOp.v" holds:
  - the nine op constants and the MD_OP width (4);
  - state encodings IDLE=0, MUL_BUSY=1, DIV_BUSY=2.
- Sub-module md_calc: purely combinational. Inputs are op, src1 and src2; outputs are hi_res, lo_res and div_zero. It isolates the arithmetic from the FSM.
- mdu_ctrl contains the FSM, counter, pending regs, HI/LO and the stall logic.

Test Plan:
- Test 1, mult:
  - Stimulus: reset; mult src1=0xFFFFFFFE (-2), src2=3.
  - Required: E_busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mflo next cycle gives 0xFFFFFFFA.
- Test 2, multu:
  - Stimulus: multu src1=0xFFFFFFFF, src2=2.
  - Required: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Test 3, div and divu:
  - Stimulus: div src1=-7 (0xFFFFFFF9), src2=2.
  - Required: 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Stimulus: divu src1=7, src2=0 with HI=LO=0x12345678 preloaded via mthi/mtlo.
  - Required: 10 busy cycles; HI/LO remain 0x12345678.
- Test 4, stall:
  - Stimulus: mult issued with D_isMD=1 held.
  - Required: MDU_stall=1 in the start cycle and all 5 busy cycles, then 0.
  - Stimulus: D_isMD=0.
  - Required: MDU_stall stays 0 throughout.
- Test 5, cancel:
  - Stimulus: mult with E_cancel=1.
  - Required: E_busy stays 0; HI/LO unchanged.
  - Stimulus: mtlo 0xABCD with E_cancel=1.
  - Required: LO unchanged.
  - Stimulus: E_cancel pulsed during cycle 3 of an in-flight div.
  - Required: div still commits at cycle 10.
- Test 6, reset mid-op:
  - Stimulus: reset asserted in busy cycle 2 of a div.
  - Required: next cycle E_busy=0, HI=LO=0; a fresh mthi 0x55 then mfhi returns 0x00000055.
